button_conditioner: RTL
=======================

Name: button_conditioner

Overview:
- Sits directly downstream of the 2-FF input synchronizer. It consumes the synchronized user-button levels (clear, record, play, track-number).
- Debounces each button, converts presses into single-cycle command pulses with fixed priority, and maintains the wrap-around track-select register.
- Outputs drive the recorder control FSM and the memory address base.

Parameters:
- DEBOUNCE_CYCLES, 1000000, cycles a raw level must differ from the debounced level before it is accepted (10 ms at 100 MHz); minimum 2.
- NUM_TRACKS, 4, number of selectable tracks; minimum 2.
- REPEAT_DELAY, 50000000, hold cycles before the first auto-repeat of num (used only with BTN_REPEAT_EN).
- REPEAT_PERIOD, 20000000, cycles between subsequent auto-repeats (used only with BTN_REPEAT_EN).
- TRK_W = clog2(NUM_TRACKS) is a derived localparam, not overridable.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- in_rst  in  1  synchronized clear button level
- in_rec  in  1  synchronized record button level
- in_ply  in  1  synchronized play button level
- in_num  in  1  synchronized track-advance button level
- db_rec  out  1  debounced record level (held while pressed)
- db_ply  out  1  debounced play level
- cmd_clear  out  1  one-cycle pulse, clear press accepted
- cmd_rec  out  1  one-cycle pulse, record press accepted
- cmd_play  out  1  one-cycle pulse, play press accepted
- track_adv  out  1  one-cycle pulse, track register changed by num
- track  out  TRK_W  current track index, 0..NUM_TRACKS-1

Behaviour:
- Reset (rst=0, async): all debounce counters 0, all debounced levels 0, all pulses 0, track 0. This applies mid-count, and a press in progress is discarded. After release, inputs already high are accepted as new presses after DEBOUNCE_CYCLES.
- Debouncer, one per button, identical:
  - Holds a stable level db and a counter.
  - If raw == db, the counter clears to 0.
  - If raw != db, the counter increments.
  - When the counter equals DEBOUNCE_CYCLES-1 and raw != db, the next edge sets db <= raw and clears the counter.
  - A clean input change therefore appears on db exactly DEBOUNCE_CYCLES cycles after it first appears on the input.
  - Any glitch shorter than DEBOUNCE_CYCLES restarts the count and has no effect.
- Press detect: a registered rise of db (0->1) makes the press event true for exactly one cycle. Release (1->0) produces no command.
- Command pulses are registered, one cycle after the db rise, and are mutually exclusive in a cycle. Priority when press events coincide:
  - clear suppresses rec, ply and num in that cycle.
  - rec suppresses ply.
  - num is independent of rec/ply.
  - Suppressed events are lost, not deferred.
- Track register:
  - A num press increments track. At NUM_TRACKS-1 it wraps to 0.
  - track_adv pulses in the same cycle that track updates.
  - cmd_clear forces track to 0 and does not pulse track_adv.
- Latency: button edge on the input -> cmd pulse = DEBOUNCE_CYCLES+1 cycles.
- Holding a button produces one pulse only; the next pulse requires release (debounced) and a new press.

Optional Feature:
- Macro: BTN_REPEAT_EN.
- Defined:
  - While db_num stays high, a hold counter runs.
  - The first auto-advance fires REPEAT_DELAY cycles after the initial press pulse, then every REPEAT_PERIOD cycles.
  - Each auto-advance increments track with wrap and pulses track_adv.
  - The hold counter clears on db_num release, on cmd_clear, or on reset.
  - A clear press in the same cycle as a repeat suppresses the repeat.
- Undefined: no hold counter exists and num behaves as one press = one advance.

Test Plan (DEBOUNCE_CYCLES=4, NUM_TRACKS=4, REPEAT_DELAY=10, REPEAT_PERIOD=3):
- Reset release, all inputs 0 -> all outputs 0 and track=0 for 20 cycles.
- in_rec 0->1 held 10 cycles -> db_rec rises 4 cycles after the edge. cmd_rec is high for exactly 1 cycle, 5 cycles after the edge. No further cmd_rec while held.
- in_ply pulse of 3 cycles, then pulses of 2 cycles separated by 1 low cycle -> db_ply stays 0 and cmd_play never asserts.
- Five separate clean num presses -> track sequence 1,2,3,0,1, with one track_adv per press.
- in_rst and in_rec and in_num rising on the same cycle with track=2 -> cmd_clear only, track=0, no cmd_rec, no track_adv.
- rst asserted low while in_num has been high for 2 cycles, released, in_num still high -> no pulse before release. track_adv arrives 5 cycles after reset release. With BTN_REPEAT_EN, holding num 20 cycles gives advances at press+0, +10, +13, +16, +19.

Source files
------------

// File: rtl/button_conditioner.sv
// Button conditioner: per-button debounce, prioritised one-cycle command pulses
// and wrap-around track select. Define BTN_REPEAT_EN to enable num auto-repeat.
module button_conditioner #(
    parameter  int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter  int unsigned NUM_TRACKS      = 4,
    parameter  int unsigned REPEAT_DELAY    = 50000000,
    parameter  int unsigned REPEAT_PERIOD   = 20000000,
    localparam int unsigned TRK_W           = $clog2(NUM_TRACKS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_rst,
    input  logic             in_rec,
    input  logic             in_ply,
    input  logic             in_num,
    output logic             db_rec,
    output logic             db_ply,
    output logic             cmd_clear,
    output logic             cmd_rec,
    output logic             cmd_play,
    output logic             track_adv,
    output logic [TRK_W-1:0] track
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TRK_W-1:0] TRK_LAST = TRK_W'(NUM_TRACKS - 1);

    if (DEBOUNCE_CYCLES < 2 || NUM_TRACKS < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_param
        $error("button_conditioner: parameter below minimum");
    end

    // Button index: 0 clear, 1 record, 2 play, 3 num
    logic [3:0]       raw;
    logic [3:0]       db;
    logic [3:0]       db_q;
    logic [3:0]       press;
    logic [CNT_W-1:0] cnt [4];

    logic clr_ev;
    logic rec_ev;
    logic ply_ev;
    logic adv_ev;
    logic rep_hit;

    assign raw    = {in_num, in_ply, in_rec, in_rst};
    assign db_rec = db[1];
    assign db_ply = db[2];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            db   <= '0;
            db_q <= '0;
            for (int unsigned i = 0; i < 4; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            db_q <= db;
            for (int unsigned i = 0; i < 4; i++) begin
                if (raw[i] == db[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    db[i]  <= raw[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        press  = db & ~db_q;
        clr_ev = press[0];
        rec_ev = press[1] & ~press[0];
        ply_ev = press[2] & ~press[0] & ~press[1];
        adv_ev = (press[3] | rep_hit) & ~press[0];
    end

`ifdef BTN_REPEAT_EN
    localparam int unsigned HOLD_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned HOLD_W   = (HOLD_MAX < 2) ? 1 : $clog2(HOLD_MAX);

    logic [HOLD_W-1:0] hold;
    logic              first;

    // hold restarts on the press pulse so the first repeat lands REPEAT_DELAY after it
    assign rep_hit = db[3] & ~press[3] &
                     (first ? (hold == HOLD_W'(REPEAT_DELAY - 1))
                            : (hold == HOLD_W'(REPEAT_PERIOD - 1)));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold  <= '0;
            first <= 1'b1;
        end else if (clr_ev || press[3] || !db[3]) begin
            hold  <= '0;
            first <= 1'b1;
        end else if (rep_hit) begin
            hold  <= '0;
            first <= 1'b0;
        end else begin
            hold <= hold + 1'b1;
        end
    end
`else
    assign rep_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cmd_clear <= 1'b0;
            cmd_rec   <= 1'b0;
            cmd_play  <= 1'b0;
            track_adv <= 1'b0;
            track     <= '0;
        end else begin
            cmd_clear <= clr_ev;
            cmd_rec   <= rec_ev;
            cmd_play  <= ply_ev;
            track_adv <= adv_ev;
            if (clr_ev) begin
                track <= '0;
            end else if (adv_ev) begin
                track <= (track == TRK_LAST) ? '0 : track + 1'b1;
            end
        end
    end

endmodule
